coin_change_dispenser: RTL and testbench
========================================

Name: coin_change_dispenser

Overview:
- Downstream of the time/coin check stage: once a return is triggered (explicit return or wait-time expiry), this block takes the current balance and pays it out.
- Pays out one coin at a time, largest denomination first, over a valid/ready handshake to the physical coin-out interface.
- Reports the undispensable residual and a done pulse so the state-calculation stage can clear `current_total`.

Parameters:
- TOTAL_BITS, 31, width of balance values (matches `kTotalBits`).
- NUM_COINS, 3, number of denominations (matches `kNumCoins`); one-hot coin encoding, bit NUM_COINS-1 = largest.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_start  input  1  return request pulse (OR of return trigger and wait-time expiry, formed upstream).
- i_total  input  TOTAL_BITS  balance to return; sampled only when i_start is accepted.
- i_coin_ready  input  1  coin-out mechanism can accept a coin this cycle.
- o_coin_valid  output  1  o_coin holds a coin to dispense.
- o_coin  output  NUM_COINS  one-hot denomination being dispensed (bit2 = 1000, bit1 = 500, bit0 = 100).
- o_busy  output  1  high from the cycle after acceptance until return to IDLE.
- o_remaining  output  TOTAL_BITS  balance still to pay.
- o_coin_count  output  8  coins dispensed in the current or last return, saturating at 255.
- o_done  output  1  single-cycle completion pulse.
- o_residual  output  TOTAL_BITS  amount left below the smallest coin; valid while o_done is high.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; all outputs 0 (o_coin_valid, o_coin, o_busy, o_remaining, o_coin_count, o_done, o_residual).
- Reset mid-dispense aborts at once. No further coins are dispensed. No o_done is generated.
- All outputs are registered. There is no combinational path from inputs to outputs.
- IDLE:
  - i_start=1 at edge N: latch i_total into remaining, clear o_coin_count, go to SELECT.
  - o_busy=1 from N+1.
- SELECT (1 cycle): pick the largest coin value <= remaining.
  - If none exists (remaining < 100), go to DONE.
  - Otherwise drive o_coin one-hot, set o_coin_valid=1, go to DISPENSE.
  - First coin is therefore visible at N+2.
- DISPENSE:
  - o_coin and o_coin_valid are held stable until i_coin_ready=1 at an edge (the handshake).
  - On the handshake: subtract the coin value from remaining; increment o_coin_count (saturating).
  - In the same edge, select the next coin from the post-subtraction value. The next coin is presented the following cycle, so throughput is one coin per cycle while ready is held high.
  - If the post-subtraction value < 100, deassert o_coin_valid and go to DONE.
- DONE (1 cycle): o_done=1, o_residual=remaining, o_busy=0 next cycle, go to IDLE.
  - o_remaining keeps the residual until the next start.
- i_start while not IDLE is ignored. A start is never queued.
- i_start in the same cycle as o_done is ignored. Only IDLE accepts a start.
- i_total=0 at start: SELECT goes directly to DONE. o_done arrives at N+2, with no coin and residual 0.
- Arithmetic:
  - Unsigned, TOTAL_BITS wide.
  - Subtraction only ever occurs when remaining >= coin value, so no underflow is possible.
  - Greedy selection is exact for the 100/500/1000 set.
- o_coin is never multi-hot. o_coin is 0 whenever o_coin_valid=0.

Decomposition:
- Shared definitions file (`vending_machine_def.v`) holds `kTotalBits`, `kNumCoins`, and the coin value constants (100/500/1000).
- FSM state encodings (IDLE, SELECT, DISPENSE, DONE) are local `localparam`s.
- One sub-module, coin_select: combinational, takes remaining and returns the one-hot largest-fitting coin plus its value. It is instantiated twice, for SELECT and for post-subtraction reselection, or shared via a mux.

Test Plan:
- i_total=1600, i_start pulse, i_coin_ready=1 constant -> coins 1000, 500, 100 on three consecutive cycles starting N+2; o_done at N+5; o_residual=0; o_coin_count=3.
- i_total=2700, ready=1 -> sequence 1000, 1000, 500, 100, 100; count=5; residual 0; o_busy high for exactly the dispense span plus SELECT/DONE.
- i_total=250, ready held low 3 cycles after first valid -> first coin 100 stable for 4 cycles with valid=1, then 100 again; residual=50; o_remaining=50 after done.
- i_total=0 -> no o_coin_valid; o_done at N+2; residual 0; count 0.
- Second i_start mid-dispense of 1600 with i_total=9999 -> ignored; output remains 1000, 500, 100.
- reset_n low during the second coin of 2700 -> all outputs 0 asynchronously; no o_done; a subsequent start with 500 dispenses one 500 coin normally.

Source files
------------

// File: rtl/coin_change_dispenser_pkg.sv
// Shared definitions for the coin change dispenser: widths, coin denominations,
// FSM state encoding and a saturating counter helper.
package coin_change_dispenser_pkg;

    localparam int CCD_TOTAL_BITS = 31;
    localparam int CCD_NUM_COINS  = 3;

    localparam int unsigned COIN_VAL_SMALL = 32'd100;
    localparam int unsigned COIN_VAL_MID   = 32'd500;
    localparam int unsigned COIN_VAL_LARGE = 32'd1000;

    localparam logic [CCD_NUM_COINS-1:0] COIN_SMALL = 3'b001;
    localparam logic [CCD_NUM_COINS-1:0] COIN_MID   = 3'b010;
    localparam logic [CCD_NUM_COINS-1:0] COIN_LARGE = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/coin_change_dispenser_coin_select.sv
// Combinational greedy picker: largest denomination not exceeding the balance,
// returned one-hot together with its value (zero when nothing fits).
module coin_change_dispenser_coin_select
    import coin_change_dispenser_pkg::*;
#(
    parameter int TOTAL_BITS = CCD_TOTAL_BITS
) (
    input  logic [TOTAL_BITS-1:0]    remaining_i,
    output logic [CCD_NUM_COINS-1:0] coin_o,
    output logic [TOTAL_BITS-1:0]    value_o
);

    // Priority compare from the largest denomination downwards.
    always_comb begin
        coin_o  = 3'b000;
        value_o = {TOTAL_BITS{1'b0}};
        if (remaining_i >= TOTAL_BITS'(COIN_VAL_LARGE)) begin
            coin_o  = COIN_LARGE;
            value_o = TOTAL_BITS'(COIN_VAL_LARGE);
        end else if (remaining_i >= TOTAL_BITS'(COIN_VAL_MID)) begin
            coin_o  = COIN_MID;
            value_o = TOTAL_BITS'(COIN_VAL_MID);
        end else if (remaining_i >= TOTAL_BITS'(COIN_VAL_SMALL)) begin
            coin_o  = COIN_SMALL;
            value_o = TOTAL_BITS'(COIN_VAL_SMALL);
        end else begin
            coin_o  = 3'b000;
            value_o = {TOTAL_BITS{1'b0}};
        end
    end

endmodule

// File: rtl/coin_change_dispenser.sv
// Pays out a latched balance one coin per handshake, largest first, then
// pulses done with the undispensable residual. All outputs are registered.
module coin_change_dispenser
    import coin_change_dispenser_pkg::*;
#(
    parameter int TOTAL_BITS = CCD_TOTAL_BITS,
    parameter int NUM_COINS  = CCD_NUM_COINS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [TOTAL_BITS-1:0] i_total,
    input  logic                  i_coin_ready,
    output logic                  o_coin_valid,
    output logic [NUM_COINS-1:0]  o_coin,
    output logic                  o_busy,
    output logic [TOTAL_BITS-1:0] o_remaining,
    output logic [7:0]            o_coin_count,
    output logic                  o_done,
    output logic [TOTAL_BITS-1:0] o_residual
);

    state_e                state_q, state_d;
    logic [TOTAL_BITS-1:0] remaining_q, remaining_d;
    logic [TOTAL_BITS-1:0] coin_val_q, coin_val_d;
    logic [TOTAL_BITS-1:0] residual_q, residual_d;
    logic [NUM_COINS-1:0]  coin_q, coin_d;
    logic [7:0]            count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [NUM_COINS-1:0]  cur_coin_s, next_coin_s;
    logic [TOTAL_BITS-1:0] cur_val_s, next_val_s, rem_sub_s;

    // Only evaluated on a handshake, where remaining_q >= coin_val_q holds.
    assign rem_sub_s = remaining_q - coin_val_q;

    coin_change_dispenser_coin_select #(.TOTAL_BITS(TOTAL_BITS)) u_sel_cur (
        .remaining_i (remaining_q),
        .coin_o      (cur_coin_s),
        .value_o     (cur_val_s)
    );

    coin_change_dispenser_coin_select #(.TOTAL_BITS(TOTAL_BITS)) u_sel_next (
        .remaining_i (rem_sub_s),
        .coin_o      (next_coin_s),
        .value_o     (next_val_s)
    );

    // Next-state and next-output logic for the dispense FSM.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin_val_d  = coin_val_q;
        residual_d  = residual_q;
        coin_d      = coin_q;
        count_d     = count_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    remaining_d = i_total;
                    count_d     = 8'd0;
                    busy_d      = 1'b1;
                    state_d     = ST_SELECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (cur_coin_s == {NUM_COINS{1'b0}}) begin
                    residual_d = remaining_q;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    coin_d     = cur_coin_s;
                    coin_val_d = cur_val_s;
                    valid_d    = 1'b1;
                    state_d    = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                if (i_coin_ready) begin
                    remaining_d = rem_sub_s;
                    count_d     = sat_inc8(count_q);
                    if (next_coin_s == {NUM_COINS{1'b0}}) begin
                        coin_d     = {NUM_COINS{1'b0}};
                        coin_val_d = {TOTAL_BITS{1'b0}};
                        valid_d    = 1'b0;
                        residual_d = rem_sub_s;
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        coin_d     = next_coin_s;
                        coin_val_d = next_val_s;
                    end
                end else begin
                    state_d = ST_DISPENSE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                coin_d  = {NUM_COINS{1'b0}};
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any return in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= {TOTAL_BITS{1'b0}};
            coin_val_q  <= {TOTAL_BITS{1'b0}};
            residual_q  <= {TOTAL_BITS{1'b0}};
            coin_q      <= {NUM_COINS{1'b0}};
            count_q     <= 8'd0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_val_q  <= coin_val_d;
            residual_q  <= residual_d;
            coin_q      <= coin_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_coin_valid = valid_q;
    assign o_coin       = coin_q;
    assign o_busy       = busy_q;
    assign o_remaining  = remaining_q;
    assign o_coin_count = count_q;
    assign o_done       = done_q;
    assign o_residual   = residual_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Self-checking bench: table-driven returns with a coin scoreboard, plus
// hand-written sequences for reset abort and counter saturation.
module tb_coin_change_dispenser;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_start;
    logic [30:0] i_total;
    logic        i_coin_ready;
    logic        o_coin_valid;
    logic [2:0]  o_coin;
    logic        o_busy;
    logic [30:0] o_remaining;
    logic [7:0]  o_coin_count;
    logic        o_done;
    logic [30:0] o_residual;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        logic [30:0]     total;
        int              hold;
        bit              inject;
        bit              start_on_done;
        int              n;
        logic [7:0][2:0] coins;
        logic [30:0]     resid;
    } vec_t;

    vec_t vecs[8];

    coin_change_dispenser dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_start      (i_start),
        .i_total      (i_total),
        .i_coin_ready (i_coin_ready),
        .o_coin_valid (o_coin_valid),
        .o_coin       (o_coin),
        .o_busy       (o_busy),
        .o_remaining  (o_remaining),
        .o_coin_count (o_coin_count),
        .o_done       (o_done),
        .o_residual   (o_residual)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " valid"}, {31'd0, o_coin_valid}, 32'd0);
        check({tag, " coin"}, {29'd0, o_coin}, 32'd0);
        check({tag, " busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, " remaining"}, {1'b0, o_remaining}, 32'd0);
        check({tag, " count"}, {24'd0, o_coin_count}, 32'd0);
        check({tag, " done"}, {31'd0, o_done}, 32'd0);
        check({tag, " residual"}, {1'b0, o_residual}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  n_start;
        int  stalls   = 0;
        int  busy_cnt = 0;
        int  pops     = 0;
        bit  done_seen = 1'b0;
        logic [2:0] got;
        logic [2:0] want;
        exp_q.delete();
        for (int k = 0; k < v.n; k++) exp_q.push_back(v.coins[k]);
        i_coin_ready = (v.hold == 0);
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_total = v.total;
        n_start = cyc + 1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (i_start) i_start = 1'b0;
            check($sformatf("v%0d coin encoding", idx),
                  {31'd0, o_coin_valid ? $onehot(o_coin) : (o_coin == 3'b000)}, 32'd1);
            if (o_busy) busy_cnt++;
            if (o_coin_valid && !i_coin_ready) begin
                if (exp_q.size() > 0)
                    check($sformatf("v%0d stalled coin", idx), {29'd0, o_coin}, {29'd0, exp_q[0]});
                if (stalls == v.hold) i_coin_ready = 1'b1;
                else stalls++;
            end
            if (o_coin_valid && i_coin_ready) begin
                got = o_coin;
                if (exp_q.size() == 0) begin
                    check($sformatf("v%0d unexpected coin", idx), {29'd0, got}, 32'd0);
                end else begin
                    want = exp_q.pop_front();
                    check($sformatf("v%0d coin %0d", idx, pops), {29'd0, got}, {29'd0, want});
                end
                pops++;
                if (v.inject && pops == 1) begin
                    i_start = 1'b1;
                    i_total = 31'd9999;
                end
            end
            if (o_done) begin
                check($sformatf("v%0d done cycle", idx), cyc, n_start + 1 + v.n + v.hold);
                check($sformatf("v%0d residual", idx), {1'b0, o_residual}, {1'b0, v.resid});
                check($sformatf("v%0d count", idx), {24'd0, o_coin_count}, v.n);
                check($sformatf("v%0d coins left", idx), exp_q.size(), 32'd0);
                if (v.start_on_done) begin
                    i_start = 1'b1;
                    i_total = 31'd1600;
                end
                done_seen = 1'b1;
                break;
            end
        end
        if (!done_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL v%0d timeout: no done within budget", idx);
            exp_q.delete();
        end
        @(negedge clk);
        i_start = 1'b0;
        check($sformatf("v%0d busy span", idx), busy_cnt, v.n + 2 + v.hold);
        check($sformatf("v%0d busy after", idx), {31'd0, o_busy}, 32'd0);
        check($sformatf("v%0d done pulse width", idx), {31'd0, o_done}, 32'd0);
        check($sformatf("v%0d remaining after", idx), {1'b0, o_remaining}, {1'b0, v.resid});
    endtask

    initial begin
        bit seen;
        vecs[0] = '{31'd1600, 0, 1'b0, 1'b0, 3, {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100}, 31'd0};
        vecs[1] = '{31'd2700, 0, 1'b0, 1'b0, 5, {3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100}, 31'd0};
        vecs[2] = '{31'd250,  3, 1'b0, 1'b0, 2, {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001}, 31'd50};
        vecs[3] = '{31'd0,    0, 1'b0, 1'b1, 0, {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000}, 31'd0};
        vecs[4] = '{31'd1600, 0, 1'b1, 1'b0, 3, {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100}, 31'd0};
        vecs[5] = '{31'd3800, 0, 1'b0, 1'b0, 7, {3'b000, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100}, 31'd0};
        vecs[6] = '{31'd199,  2, 1'b0, 1'b0, 1, {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001}, 31'd99};
        vecs[7] = '{31'd99,   0, 1'b0, 1'b0, 0, {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000}, 31'd99};

        reset_n      = 1'b1;
        i_start      = 1'b0;
        i_total      = 31'd0;
        i_coin_ready = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset asserted while the second coin of 2700 is on offer.
        i_coin_ready = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_total = 31'd2700;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (o_coin_valid && o_coin_count == 8'd1) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort second coin reached", {31'd0, seen}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("abort");
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("abort no done", {31'd0, o_done}, 32'd0);
            check("abort no coin", {31'd0, o_coin_valid}, 32'd0);
        end
        reset_n = 1'b1;
        run_vec('{31'd500, 0, 1'b0, 1'b0, 1, {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010}, 31'd0}, 8);

        // Long return: count saturates at 255.
        i_coin_ready = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_total = 31'd300050;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("saturate done seen", {31'd0, seen}, 32'd1);
        check("saturate count", {24'd0, o_coin_count}, 32'd255);
        check("saturate residual", {1'b0, o_residual}, 32'd50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
